// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator: pattern modes, LFSR taps
// and the base character code for the character-row pattern.
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_NOISE    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_CHARROW  = 2'd3
  } mode_e;

  localparam logic [7:0] CHAR_BASE = 8'h30;

  // Right-shifting Galois masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/pattern_if.sv
// Pixel-coordinate / control inputs and colour outputs of the pattern generator.
interface pattern_if #(
  parameter int CX_WIDTH     = 10,
  parameter int CY_WIDTH     = 10,
  parameter int CHAN_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3
);
  logic [CX_WIDTH-1:0]                cx;
  logic [CY_WIDTH-1:0]                cy;
  logic [1:0]                         mode_sel;
  logic                               mode_load;
  logic                               freeze;
  logic [NUM_CHANNELS*CHAN_WIDTH-1:0] rgb;
  logic [7:0]                         codepoint;
  logic                               frame_start;
  logic [7:0]                         frame_count;
  logic [1:0]                         mode;

  modport master (
    output cx, cy, mode_sel, mode_load, freeze,
    input  rgb, codepoint, frame_start, frame_count, mode
  );

  modport slave (
    input  cx, cy, mode_sel, mode_load, freeze,
    output rgb, codepoint, frame_start, frame_count, mode
  );
endinterface

// File: rtl/pattern_lfsr.sv
// Galois LFSR noise source with hold enable; an all-zero state (only reachable
// through upset) is replaced by the seed on the following cycle.
module pattern_lfsr
  import pattern_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic             enable,
  output logic [WIDTH-1:0] state
);
  localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_step;

  assign state_step = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n)                state_q <= SEED;
    else if (state_q == '0)    state_q <= SEED;
    else if (enable)           state_q <= state_step;
  end

  assign state = state_q;
endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: one-cycle registered colour per pixel, pattern mode
// switched only at frame boundaries.
//   state          | meaning
//   MODE_NOISE     | LFSR noise on every channel
//   MODE_BARS      | eight vertical colour bars, white to black
//   MODE_GRADIENT  | cx / cy / frame_count ramps
//   MODE_CHARROW   | flat colour from the character-row codepoint
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int CX_WIDTH     = 10,
  parameter int CY_WIDTH     = 10,
  parameter int CHAN_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int LFSR_WIDTH   = 24,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int CELL_SHIFT   = 4
) (
  input  logic     clk_pixel,
  input  logic     rst_n,
  pattern_if.slave pif
);
  localparam int RGB_W = NUM_CHANNELS * CHAN_WIDTH;
  localparam int ROW_W = CY_WIDTH - CELL_SHIFT;

  mode_e                  mode_q, mode_d, pending_q, pending_d;
  logic [7:0]             fc_q, fc_d, cp_q, cp_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [RGB_W-1:0]       rgb_q, rgb_d;
  logic                   fs_q;
  logic                   boundary, active;
  logic [LFSR_WIDTH-1:0]  lfsr_state;
  logic [CHAN_WIDTH-1:0]  cx_al, cy_al, fc_al, cp_al;
  logic [CX_WIDTH+2:0]    cx_x8;
  logic [2:0]             bar_idx, bar_inv;
  logic [RGB_W-1:0]       noise_rgb, bars_rgb, grad_rgb;

  assign boundary = (pif.cx == '0) && (pif.cy == '0);
  assign active   = (pif.cx < CX_WIDTH'(FRAME_WIDTH)) && (pif.cy < CY_WIDTH'(FRAME_HEIGHT));

  pattern_lfsr #(.WIDTH(LFSR_WIDTH)) u_lfsr (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .enable    (!pif.freeze),
    .state     (lfsr_state)
  );

  // MSB-align each source onto a colour channel.
  generate
    if (CX_WIDTH >= CHAN_WIDTH) begin : g_cx_trunc
      assign cx_al = pif.cx[CX_WIDTH-1 -: CHAN_WIDTH];
    end else begin : g_cx_ext
      assign cx_al = {pif.cx, {(CHAN_WIDTH-CX_WIDTH){1'b0}}};
    end
    if (CY_WIDTH >= CHAN_WIDTH) begin : g_cy_trunc
      assign cy_al = pif.cy[CY_WIDTH-1 -: CHAN_WIDTH];
    end else begin : g_cy_ext
      assign cy_al = {pif.cy, {(CHAN_WIDTH-CY_WIDTH){1'b0}}};
    end
    if (CHAN_WIDTH <= 8) begin : g_byte_trunc
      assign fc_al = fc_d[7 -: CHAN_WIDTH];
      assign cp_al = cp_d[7 -: CHAN_WIDTH];
    end else begin : g_byte_ext
      assign fc_al = {fc_d, {(CHAN_WIDTH-8){1'b0}}};
      assign cp_al = {cp_d, {(CHAN_WIDTH-8){1'b0}}};
    end
  endgenerate

  // Mode, frame counter and character-row tracking.
  always_comb begin
    pending_d = pif.mode_load ? mode_e'(pif.mode_sel) : pending_q;
    mode_d    = mode_q;
    fc_d      = fc_q;
    if (boundary) begin
      mode_d = pending_d;
      if (!pif.freeze) fc_d = fc_q + 8'd1;
    end

    cp_d  = cp_q;
    row_d = row_q;
    if (pif.cy == '0) begin
      cp_d  = CHAR_BASE;
      row_d = '0;
    end else if (pif.cy[CY_WIDTH-1:CELL_SHIFT] != row_q) begin
      cp_d  = cp_q + 8'd1;
      row_d = pif.cy[CY_WIDTH-1:CELL_SHIFT];
    end
  end

  // Colour sources; the boundary pixel already uses the mode of the new frame.
  always_comb begin
    cx_x8   = {pif.cx, 3'b000};
    bar_idx = 3'd0;
    for (int b = 1; b < 8; b++)
      if (cx_x8 >= (CX_WIDTH+3)'(b * FRAME_WIDTH)) bar_idx = 3'(b);
    bar_inv = ~bar_idx;

    noise_rgb = '0;
    bars_rgb  = '0;
    grad_rgb  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      for (int j = 0; j < CHAN_WIDTH; j++)
        noise_rgb[i*CHAN_WIDTH+j] = lfsr_state[(i*CHAN_WIDTH+j) % LFSR_WIDTH];
      bars_rgb[i*CHAN_WIDTH +: CHAN_WIDTH] = {CHAN_WIDTH{bar_inv[i % 3]}};
      grad_rgb[i*CHAN_WIDTH +: CHAN_WIDTH] = (i == 0) ? cx_al : (i == 1) ? cy_al : fc_al;
    end

    rgb_d = '0;
    if (active) begin
      case (mode_d)
        MODE_NOISE:    rgb_d = noise_rgb;
        MODE_BARS:     rgb_d = bars_rgb;
        MODE_GRADIENT: rgb_d = grad_rgb;
        MODE_CHARROW:  rgb_d = {NUM_CHANNELS{cp_al}};
        default:       rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_NOISE;
      pending_q <= MODE_NOISE;
      fc_q      <= 8'd0;
      cp_q      <= CHAR_BASE;
      row_q     <= '0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pending_q <= pending_d;
      fc_q      <= fc_d;
      cp_q      <= cp_d;
      row_q     <= row_d;
      rgb_q     <= rgb_d;
      fs_q      <= boundary;
    end
  end

  assign pif.rgb         = rgb_q;
  assign pif.codepoint   = cp_q;
  assign pif.frame_start = fs_q;
  assign pif.frame_count = fc_q;
  assign pif.mode        = mode_q;
endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: reset, noise, bars, gradient, character rows,
// freeze, mid-frame reset and a 16-bit LFSR period sweep on a second instance.
module tb_pattern_gen;
  logic clk_pixel = 1'b0;
  logic rst_n     = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  logic [23:0] lfsr_m    = 24'h1;
  logic [23:0] lfsr_pre  = 24'h1;
  logic [23:0] frozen;
  int   pulses;
  int   zeros, ones;

  always #5 clk_pixel = ~clk_pixel;

  pattern_if bus ();
  pattern_if bus16 ();

  pattern_gen dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .pif       (bus)
  );

  pattern_gen #(.LFSR_WIDTH(16)) dut16 (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .pif       (bus16)
  );

  function automatic logic [23:0] galois24(input logic [23:0] s);
    return s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int x, input int y);
    bus.cx = 10'(x);
    bus.cy = 10'(y);
    lfsr_pre = lfsr_m;
    @(posedge clk_pixel);
    if (!bus.freeze) lfsr_m = galois24(lfsr_m);
    #1;
  endtask

  task automatic load(input logic [1:0] m);
    bus.mode_sel  = m;
    bus.mode_load = 1'b1;
  endtask

  initial begin
    bus.cx = 10'd5; bus.cy = 10'd5; bus.mode_sel = 2'd0; bus.mode_load = 1'b0; bus.freeze = 1'b0;
    bus16.cx = 10'd0; bus16.cy = 10'd0; bus16.mode_sel = 2'd0; bus16.mode_load = 1'b0;
    bus16.freeze = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_rgb",   32'(bus.rgb), 32'h0);
    check("rst_cp",    32'(bus.codepoint), 32'h30);
    check("rst_fs",    32'(bus.frame_start), 32'h0);
    check("rst_fc",    32'(bus.frame_count), 32'h0);
    check("rst_mode",  32'(bus.mode), 32'h0);
    rst_n = 1'b1;
    lfsr_m = 24'h1;

    // Noise straight after reset: seed then successive Galois steps
    step(10, 10); check("noise0", 32'(bus.rgb), 32'h000001);
    step(11, 10); check("noise1", 32'(bus.rgb), 32'hE10000);
    step(12, 10); check("noise2", 32'(bus.rgb), 32'h708000);
    step(13, 10); check("noise3", 32'(bus.rgb), 32'h384000);
    step(14, 10); check("noise4", 32'(bus.rgb), 32'(lfsr_pre));

    // Load BARS mid-frame; applies at next boundary only
    load(2'd1); step(200, 100); bus.mode_load = 1'b0;
    check("pend_mode_a", 32'(bus.mode), 32'h0);
    step(639, 479);
    check("pend_mode_b", 32'(bus.mode), 32'h0);
    check("pend_fs", 32'(bus.frame_start), 32'h0);
    step(0, 0);
    check("bars_mode", 32'(bus.mode), 32'h1);
    check("bars_fs",   32'(bus.frame_start), 32'h1);
    check("bars_fc",   32'(bus.frame_count), 32'h1);
    check("bars_cx0",  32'(bus.rgb), 32'hFFFFFF);
    step(639, 0);
    check("bars_cx639", 32'(bus.rgb), 32'h000000);
    check("bars_fs_off", 32'(bus.frame_start), 32'h0);
    step(80, 0);  check("bars_cx80",  32'(bus.rgb), 32'hFFFF00);
    step(320, 5); check("bars_cx320", 32'(bus.rgb), 32'h00FFFF);
    step(700, 5); check("bars_outside", 32'(bus.rgb), 32'h0);

    // GRADIENT loaded in the boundary cycle itself
    load(2'd2); step(0, 0); bus.mode_load = 1'b0;
    check("grad_mode", 32'(bus.mode), 32'h2);
    check("grad_fc2",  32'(bus.frame_count), 32'h2);
    check("grad_org",  32'(bus.rgb), 32'h020000);
    step(640, 10); check("grad_cx640", 32'(bus.rgb), 32'h0);
    step(0, 0);    check("grad_fc3",   32'(bus.frame_count), 32'h3);
    step(512, 256); check("grad_mid",  32'(bus.rgb), 32'h034080);
    step(5, 480);   check("grad_cy480", 32'(bus.rgb), 32'h0);

    // CHARROW sweep over every active row
    load(2'd3); step(0, 0); bus.mode_load = 1'b0;
    check("char_mode", 32'(bus.mode), 32'h3);
    check("char_fc",   32'(bus.frame_count), 32'h4);
    check("char_cp0",  32'(bus.codepoint), 32'h30);
    check("char_rgb0", 32'(bus.rgb), 32'h303030);
    for (int y = 1; y < 480; y++) begin
      logic [7:0] exp_cp;
      exp_cp = 8'(8'h30 + (y / 16));
      step(100, y);
      check("char_cp",  32'(bus.codepoint), 32'(exp_cp));
      check("char_rgb", 32'(bus.rgb), {8'h0, exp_cp, exp_cp, exp_cp});
    end
    check("char_last", 32'(bus.codepoint), 32'h4D);

    // Freeze across two frame boundaries in NOISE mode
    load(2'd0); step(0, 0); bus.mode_load = 1'b0;
    check("frz_fc_pre", 32'(bus.frame_count), 32'h5);
    bus.freeze = 1'b1;
    pulses = 0;
    step(10, 10);
    frozen = lfsr_pre;
    check("frz_rgb0", 32'(bus.rgb), 32'(frozen));
    step(0, 0);  pulses += int'(bus.frame_start);
    check("frz_fc1",  32'(bus.frame_count), 32'h5);
    check("frz_rgb1", 32'(bus.rgb), 32'(frozen));
    step(3, 3);  pulses += int'(bus.frame_start);
    check("frz_rgb2", 32'(bus.rgb), 32'(frozen));
    step(0, 0);  pulses += int'(bus.frame_start);
    check("frz_fc2",  32'(bus.frame_count), 32'h5);
    check("frz_pulses", 32'(pulses), 32'd2);
    bus.freeze = 1'b0;
    step(1, 1);  check("unfrz_rgb0", 32'(bus.rgb), 32'(frozen));
    step(2, 1);  check("unfrz_rgb1", 32'(bus.rgb), 32'(galois24(frozen)));
    step(0, 0);  check("unfrz_fc",   32'(bus.frame_count), 32'h6);

    // Asynchronous reset mid-frame while in GRADIENT
    load(2'd2); step(0, 0); bus.mode_load = 1'b0;
    check("mrst_mode_pre", 32'(bus.mode), 32'h2);
    step(100, 100);
    check("mrst_rgb_pre", 32'(bus.rgb), 32'h071919);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_rgb",  32'(bus.rgb), 32'h0);
    check("mrst_cp",   32'(bus.codepoint), 32'h30);
    check("mrst_fs",   32'(bus.frame_start), 32'h0);
    check("mrst_fc",   32'(bus.frame_count), 32'h0);
    check("mrst_mode", 32'(bus.mode), 32'h0);
    @(posedge clk_pixel); #1;
    rst_n  = 1'b1;
    lfsr_m = 24'h1;
    step(100, 100);
    check("mrst_mode_after", 32'(bus.mode), 32'h0);
    check("mrst_noise_seed", 32'(bus.rgb), 32'h000001);

    // 16-bit LFSR: one full period never hits zero and visits the seed once
    zeros = 0;
    ones  = 0;
    for (int n = 0; n < 65535; n++) begin
      @(posedge clk_pixel); #1;
      if (bus16.rgb == 24'h0)      zeros++;
      if (bus16.rgb == 24'h010001) ones++;
    end
    check("lfsr16_zero", 32'(zeros), 32'd0);
    check("lfsr16_seed", 32'(ones),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
